// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->EX operand bypass, saturating bubble counter.
// Latency 1 cycle; stall holds EX (held operands still refreshed from WB), flush wins over stall.
module id_ex_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [3:0]        id_funct,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [3:0]        ex_funct,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              valid_q;
    logic [XLEN-1:0]   pc_q, rd1_q, rd2_q, imm_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic [3:0]        funct_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              wb_live;
    logic [XLEN-1:0]   rd1_d, rd2_d;
    logic              hold_fwd1, hold_fwd2;
    logic              bubble;

    // x0 reads as zero no matter what the register file returned.
    always_comb begin
        wb_live   = wb_regwrite && (wb_rd != 5'd0);
        rd1_d     = id_rd1;
        rd2_d     = id_rd2;
        if (id_rs1 == 5'd0)
            rd1_d = '0;
        else if (wb_live && (wb_rd == id_rs1))
            rd1_d = wb_data;
        if (id_rs2 == 5'd0)
            rd2_d = '0;
        else if (wb_live && (wb_rd == id_rs2))
            rd2_d = wb_data;
        hold_fwd1 = valid_q && wb_live && (wb_rd == rs1_q);
        hold_fwd2 = valid_q && wb_live && (wb_rd == rs2_q);
        bubble    = flush || (!stall && !id_valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            funct_q <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
                pc_q    <= '0;
                rs1_q   <= '0;
                rs2_q   <= '0;
                rd_q    <= '0;
                rd1_q   <= '0;
                rd2_q   <= '0;
                imm_q   <= '0;
                funct_q <= '0;
                ctrl_q  <= '0;
            end else if (stall) begin
                // Older instructions retiring in WB must reach the held operands.
                if (hold_fwd1) rd1_q <= wb_data;
                if (hold_fwd2) rd2_q <= wb_data;
            end else begin
                valid_q <= id_valid;
                pc_q    <= id_pc;
                rs1_q   <= id_rs1;
                rs2_q   <= id_rs2;
                rd_q    <= id_rd;
                rd1_q   <= rd1_d;
                rd2_q   <= rd2_d;
                imm_q   <= id_imm;
                funct_q <= id_funct;
                ctrl_q  <= id_valid ? id_ctrl : '0;
            end
            if (bubble && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_rd1       = rd1_q;
    assign ex_rd2       = rd2_q;
    assign ex_imm       = imm_q;
    assign ex_funct     = funct_q;
    assign ex_ctrl      = ctrl_q;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: scoreboard of expected EX state, default and 4-bit-counter instances.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [3:0]  funct;
        logic [7:0]  ctrl;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, stall, flush, wb_regwrite;
    logic [63:0] id_pc, id_rd1, id_rd2, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [3:0]  id_funct;
    logic [7:0]  id_ctrl;

    logic        ex_valid, ex4_valid;
    logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm, ex4_pc, ex4_rd1, ex4_rd2, ex4_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex4_rs1, ex4_rs2, ex4_rd;
    logic [3:0]  ex_funct, ex4_funct;
    logic [7:0]  ex_ctrl, ex4_ctrl;
    logic [31:0] bubble_count;
    logic [3:0]  bubble_count4;

    int   errors = 0;
    int   checks = 0;
    exp_t m;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .stall(stall), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_funct(ex_funct), .ex_ctrl(ex_ctrl),
        .bubble_count(bubble_count)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .stall(stall), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex4_valid), .ex_pc(ex4_pc), .ex_rs1(ex4_rs1),
        .ex_rs2(ex4_rs2), .ex_rd(ex4_rd), .ex_rd1(ex4_rd1), .ex_rd2(ex4_rd2),
        .ex_imm(ex4_imm), .ex_funct(ex4_funct), .ex_ctrl(ex4_ctrl),
        .bubble_count(bubble_count4)
    );

    // Expected next EX state, pushed when the stimulus is driven, compared after the edge.
    task automatic step();
        exp_t n;
        exp_t e;
        exp_t obs;
        n = m;
        if (flush) begin
            n      = '0;
            n.cnt  = m.cnt;
            n.cnt4 = m.cnt4;
        end else if (stall) begin
            if (m.valid && wb_regwrite && wb_rd != 5'd0 && wb_rd == m.rs1) n.rd1 = wb_data;
            if (m.valid && wb_regwrite && wb_rd != 5'd0 && wb_rd == m.rs2) n.rd2 = wb_data;
        end else begin
            n.valid = id_valid;
            n.pc    = id_pc;
            n.rs1   = id_rs1;
            n.rs2   = id_rs2;
            n.rd    = id_rd;
            n.rd1   = (id_rs1 == 5'd0) ? 64'd0 :
                      (wb_regwrite && wb_rd == id_rs1) ? wb_data : id_rd1;
            n.rd2   = (id_rs2 == 5'd0) ? 64'd0 :
                      (wb_regwrite && wb_rd == id_rs2) ? wb_data : id_rd2;
            n.imm   = id_imm;
            n.funct = id_funct;
            n.ctrl  = id_valid ? id_ctrl : 8'd0;
        end
        if (flush || (!stall && !id_valid)) begin
            if (n.cnt != 32'hFFFF_FFFF) n.cnt = n.cnt + 32'd1;
            if (n.cnt4 != 4'hF) n.cnt4 = n.cnt4 + 4'd1;
        end
        m = n;
        sb_q.push_back(n);
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e   = sb_q.pop_front();
            obs = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm,
                   ex_funct, ex_ctrl, bubble_count, bubble_count4};
            if (obs !== e) begin
                errors++;
                $display("FAIL ex_state: got %h required %h", obs, e);
            end
            checks++;
            if ({ex4_valid, ex4_pc, ex4_rs1, ex4_rs2, ex4_rd, ex4_rd1, ex4_rd2, ex4_imm, ex4_funct, ex4_ctrl}
                !== {e.valid, e.pc, e.rs1, e.rs2, e.rd, e.rd1, e.rd2, e.imm, e.funct, e.ctrl}) begin
                errors++;
                $display("FAIL ex_state_cnt4: got pc=%h rd1=%h rd2=%h required pc=%h rd1=%h rd2=%h",
                         ex4_pc, ex4_rd1, ex4_rd2, e.pc, e.rd1, e.rd2);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_funct = '0; id_ctrl = '0;
        stall = 1'b0; flush = 1'b0; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_funct, ex_ctrl, bubble_count, bubble_count4} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ctrl=%h cnt=%0d required all zero", ex_valid, ex_ctrl, bubble_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m = '0;
        sb_q.delete();
    endtask

    task automatic test_bypass();
        idle_inputs();
        id_valid = 1'b1; id_pc = 64'h1000; id_rs1 = 5'd3; id_rd1 = 64'd12; id_rd = 5'd8;
        id_ctrl = 8'h11; id_imm = 64'hFFFF_FFFF_FFFF_FFF0; id_funct = 4'hA;
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'd99;
        step();
        checks++;
        if (ex_rd1 !== 64'd99) begin
            errors++;
            $display("FAIL bypass_rs1: got %0d required 99", ex_rd1);
        end
        wb_rd = 5'd0;
        step();
        checks++;
        if (ex_rd1 !== 64'd12) begin
            errors++;
            $display("FAIL bypass_wb_rd_x0: got %0d required 12", ex_rd1);
        end
        id_rs1 = 5'd6; id_rs2 = 5'd6; id_rd1 = 64'd1; id_rd2 = 64'd2;
        wb_rd = 5'd6; wb_data = 64'd77;
        step();
        checks++;
        if (ex_rd1 !== 64'd77 || ex_rd2 !== 64'd77) begin
            errors++;
            $display("FAIL bypass_both: got rd1=%0d rd2=%0d required 77 77", ex_rd1, ex_rd2);
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 5'd2; id_rd1 = 64'd5; id_rs2 = 5'd0; id_rd2 = 64'd7;
        wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 64'd123;
        step();
        checks++;
        if (ex_rd2 !== 64'd0) begin
            errors++;
            $display("FAIL x0_operand: got %0d required 0", ex_rd2);
        end
    endtask

    task automatic test_stall_refresh();
        idle_inputs();
        id_valid = 1'b1; id_pc = 64'h2000; id_rs1 = 5'd1; id_rd1 = 64'd3;
        id_rs2 = 5'd4; id_rd2 = 64'd9; id_rd = 5'd10; id_ctrl = 8'h31; id_funct = 4'h2;
        step();
        checks++;
        if (ex_rd2 !== 64'd9) begin
            errors++;
            $display("FAIL stall_preload: got %0d required 9", ex_rd2);
        end
        stall = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 64'd55;
        id_pc = 64'h2004; id_rs2 = 5'd9; id_rd2 = 64'd1; id_ctrl = 8'h02;
        step();
        checks++;
        if (ex_rd2 !== 64'd55 || ex_pc !== 64'h2000 || ex_rd1 !== 64'd3 || ex_ctrl !== 8'h31) begin
            errors++;
            $display("FAIL stall_refresh: got rd2=%0d pc=%h rd1=%0d ctrl=%h required 55 2000 3 31",
                     ex_rd2, ex_pc, ex_rd1, ex_ctrl);
        end
        stall = 1'b0;
    endtask

    task automatic test_flush_priority();
        logic [31:0] want;
        idle_inputs();
        stall = 1'b1; flush = 1'b1; id_valid = 1'b1; id_ctrl = 8'hFF; id_pc = 64'h3000;
        want = m.cnt + 32'd1;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || bubble_count !== want) begin
            errors++;
            $display("FAIL flush_priority: got valid=%b ctrl=%h cnt=%0d required 0 00 %0d",
                     ex_valid, ex_ctrl, bubble_count, want);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] want;
        idle_inputs();
        want = m.cnt + 32'd20;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bubble_count4 !== 4'd15 || bubble_count !== want) begin
            errors++;
            $display("FAIL saturation: got cnt4=%0d cnt=%0d required 15 %0d", bubble_count4, bubble_count, want);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_pc       = {$urandom, $urandom};
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 31));
            id_rd1      = {$urandom, $urandom};
            id_rd2      = {$urandom, $urandom};
            id_imm      = {$urandom, $urandom};
            id_funct    = 4'($urandom_range(0, 15));
            id_ctrl     = 8'($urandom_range(0, 255));
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 6) == 0);
            wb_regwrite = ($urandom_range(0, 1) == 1);
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = {$urandom, $urandom};
            step();
        end
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        id_valid = 1'b1; id_pc = 64'h4000; id_rs1 = 5'd5; id_rd1 = 64'd44; id_ctrl = 8'h21;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_pc, ex_rd1, ex_ctrl, bubble_count, bubble_count4} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got valid=%b pc=%h ctrl=%h cnt=%0d required all zero",
                     ex_valid, ex_pc, ex_ctrl, bubble_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ex_valid, ex_pc, ex_rd1, ex_ctrl, bubble_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset_hold: got valid=%b pc=%h cnt=%0d required all zero", ex_valid, ex_pc, bubble_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m = '0;
        sb_q.delete();
        idle_inputs();
        id_valid = 1'b1; id_pc = 64'h4008;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_stall_refresh();
        test_flush_priority();
        test_saturation();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
